// File: rtl/regfile_port_arbiter.sv
// Multi-requester read/write port arbiter in front of a single-port-pair register file.
// Optional post-reset clear sequence compiled in with REGFILE_ARB_CLEAR_EN.
module regfile_port_arbiter #(
  parameter int              REQS        = 4,
  parameter int              WIDTH       = 32,
  parameter int              N           = 5,
  parameter int              SIZE        = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int             IDW         = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQS-1:0]       wr_valid,
  input  logic [REQS*N-1:0]     wr_index,
  input  logic [REQS*WIDTH-1:0] wr_data,
  output logic [REQS-1:0]       wr_ready,
  input  logic [REQS-1:0]       rd_valid,
  input  logic [REQS*N-1:0]     rd_index,
  output logic [REQS-1:0]       rd_ready,
  output logic                  rd_resp_valid,
  output logic [IDW-1:0]        rd_resp_id,
  output logic [WIDTH-1:0]      rd_resp_data,
  output logic [N-1:0]          rf_read_req,
  input  logic [WIDTH-1:0]      rf_read_resp,
  output logic                  rf_write_en,
  output logic [N-1:0]          rf_write_index,
  output logic [WIDTH-1:0]      rf_write_data,
  output logic                  busy
);

  // Round-robin pick: first set bit of valid scanning upward from ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [IDW:0] rrPick(input logic [REQS-1:0] valid,
                                          input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] win;
    int             c;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < REQS; i++) begin
      c = int'(ptr) + i;
      if (c >= REQS) c = c - REQS;
      if (!found && valid[c]) begin
        found = 1'b1;
        win   = IDW'(c);
      end
    end
    return {found, win};
  endfunction

  logic           inClear;
  logic           runActive;
  logic [IDW-1:0] wrPtr, rdPtr;
  logic [IDW:0]   wrPick, rdPick;
  logic           wrGrant, rdGrant;
  logic [IDW-1:0] wrIdx, rdIdx;

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t       state, stateNext;
  logic [N-1:0] clearCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clearCnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= stateNext;
      if (state == CLEAR) clearCnt <= clearCnt + 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    if (state == CLEAR && clearCnt == N'(SIZE - 1)) stateNext = RUN;
  end

  assign inClear = (state == CLEAR);
`else
  // CLEAR_VALUE only matters when the clear sequence is built in.
  logic unusedClearValue;
  assign unusedClearValue = ^CLEAR_VALUE;
  assign inClear          = 1'b0;
`endif

  assign runActive = rst_n && !inClear;
  assign busy      = rst_n && inClear;

  assign wrPick  = rrPick(wr_valid, wrPtr);
  assign rdPick  = rrPick(rd_valid, rdPtr);
  assign wrGrant = runActive && wrPick[IDW];
  assign rdGrant = runActive && rdPick[IDW];
  assign wrIdx   = wrPick[IDW-1:0];
  assign rdIdx   = rdPick[IDW-1:0];

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a signal unassigned, which would infer a latch.
    wr_ready       = '0;
    rd_ready       = '0;
    rf_write_en    = 1'b0;
    rf_write_index = '0;
    rf_write_data  = '0;
    rf_read_req    = '0;
`ifdef REGFILE_ARB_CLEAR_EN
    if (rst_n && inClear) begin
      rf_write_en    = 1'b1;
      rf_write_index = clearCnt;
      rf_write_data  = CLEAR_VALUE;
    end
`endif
    if (wrGrant) begin
      wr_ready[wrIdx] = 1'b1;
      rf_write_en     = 1'b1;
      rf_write_index  = wr_index[int'(wrIdx)*N +: N];
      rf_write_data   = wr_data[int'(wrIdx)*WIDTH +: WIDTH];
    end
    if (rdGrant) begin
      rd_ready[rdIdx] = 1'b1;
      rf_read_req     = rd_index[int'(rdIdx)*N +: N];
    end
  end

  // Pointers advance past the winner; the read response captures the
  // regfile's pre-write data, so a same-cycle write to the same index is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_id    <= '0;
      rd_resp_data  <= '0;
    end else begin
      if (wrGrant) wrPtr <= (int'(wrIdx) == REQS - 1) ? '0 : wrIdx + 1'b1;
      if (rdGrant) begin
        rdPtr        <= (int'(rdIdx) == REQS - 1) ? '0 : rdIdx + 1'b1;
        rd_resp_id   <= rdIdx;
        rd_resp_data <= rf_read_resp;
      end
      rd_resp_valid <= rdGrant;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x32 register file.
// Clear-sequence scenarios are built when REGFILE_ARB_CLEAR_EN is defined.
module tb_regfile_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   wr_valid, rd_valid;
  logic [19:0]  wr_index, rd_index;
  logic [127:0] wr_data;
  logic [3:0]   wr_ready, rd_ready;
  logic         rd_resp_valid;
  logic [1:0]   rd_resp_id;
  logic [31:0]  rd_resp_data;
  logic [4:0]   rf_read_req;
  logic [31:0]  rf_read_resp;
  logic         rf_write_en;
  logic [4:0]   rf_write_index;
  logic [31:0]  rf_write_data;
  logic         busy;

  int passCount  = 0;
  int checkCount = 0;

  logic [31:0] mem [0:31];

  regfile_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_index(rd_index), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_id(rd_resp_id), .rd_resp_data(rd_resp_data),
    .rf_read_req(rf_read_req), .rf_read_resp(rf_read_resp),
    .rf_write_en(rf_write_en), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign rf_read_resp = mem[rf_read_req];
  always @(posedge clk) if (rf_write_en) mem[rf_write_index] <= rf_write_data;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_valid = '0; rd_valid = '0; wr_index = '0; rd_index = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    int cyc;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef REGFILE_ARB_CLEAR_EN
    cyc = 0;
    #1;
    while (busy === 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    checkCount++;
    if (busy !== 1'b0) $display("FAIL reset_clear_timeout busy=%b required=0", busy);
    else passCount++;
`else
    cyc = 0;
    if (cyc != 0) $display("unreachable");
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = 4'b1111; rd_valid = 4'b1111;
    wr_index = '0; rd_index = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checkCount++;
    if (wr_ready !== 4'b0000) $display("FAIL reset_wr_ready got=%b required=0000", wr_ready); else passCount++;
    checkCount++;
    if (rd_ready !== 4'b0000) $display("FAIL reset_rd_ready got=%b required=0000", rd_ready); else passCount++;
    checkCount++;
    if (rf_write_en !== 1'b0) $display("FAIL reset_rf_write_en got=%b required=0", rf_write_en); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy); else passCount++;
    checkCount++;
    if ({rd_resp_valid, rd_resp_id, rd_resp_data} !== 35'd0)
      $display("FAIL reset_rd_resp got=%b/%0d/%h required=0/0/0", rd_resp_valid, rd_resp_id, rd_resp_data);
    else passCount++;
    @(negedge clk);
  endtask

`ifdef REGFILE_ARB_CLEAR_EN
  task automatic run_clear(input string tag);
    int cyc;
    cyc = 0;
    #1;
    while (busy === 1'b1 && cyc < 100) begin
      checkCount++;
      if (rf_write_index !== cyc[4:0] || rf_write_data !== 32'd0 || rf_write_en !== 1'b1 || wr_ready !== 4'b0000)
        $display("FAIL %s_cyc%0d idx=%0d data=%h en=%b wr_ready=%b required idx=%0d data=0 en=1 wr_ready=0000",
                 tag, cyc, rf_write_index, rf_write_data, rf_write_en, wr_ready, cyc);
      else passCount++;
      step();
      #1;
      cyc++;
    end
    checkCount++;
    if (cyc != 32) $display("FAIL %s_length got=%0d required=32", tag, cyc); else passCount++;
  endtask

  task automatic test_clear();
    wr_valid = 4'b1111;
    rst_n = 1'b1;
    run_clear("clear");
  endtask

  task automatic test_mid_clear_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    #1;
    checkCount++;
    if (rf_write_index !== 5'd10) $display("FAIL midclear_pre idx=%0d required=10", rf_write_index); else passCount++;
    #1 rst_n = 1'b0;
    #1;
    checkCount++;
    if (busy !== 1'b0 || rf_write_en !== 1'b0 || wr_ready !== 4'b0000)
      $display("FAIL midclear_async busy=%b en=%b wr_ready=%b required 0/0/0000", busy, rf_write_en, wr_ready);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("midclear_restart");
  endtask
`else
  task automatic test_first_cycle();
    wr_valid = 4'b0100; rd_valid = 4'b0000;
    wr_index[14:10] = 5'd9; wr_data[95:64] = 32'h0000_0042;
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (wr_ready !== 4'b0100) $display("FAIL first_wr_ready got=%b required=0100", wr_ready); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("FAIL first_busy got=%b required=0", busy); else passCount++;
    checkCount++;
    if (rf_write_en !== 1'b1 || rf_write_index !== 5'd9 || rf_write_data !== 32'h42)
      $display("FAIL first_rf_write en=%b idx=%0d data=%h required 1/9/42", rf_write_en, rf_write_index, rf_write_data);
    else passCount++;
    step();
  endtask
`endif

  task automatic test_write_rr();
    logic [3:0] expGrant;
    int g;
    do_reset();
    wr_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wr_index[i*5 +: 5] = 5'(16 + i);
      wr_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      expGrant = 4'b0001 << g;
      #1;
      checkCount++;
      if (wr_ready !== expGrant || rf_write_en !== 1'b1 || rf_write_index !== 5'(16 + g) ||
          rf_write_data !== 32'hA000_0000 + 32'(g))
        $display("FAIL write_rr_%0d wr_ready=%b idx=%0d data=%h required %b/%0d/%h",
                 k, wr_ready, rf_write_index, rf_write_data, expGrant, 16 + g, 32'hA000_0000 + 32'(g));
      else passCount++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_read();
    wr_valid = 4'b0010; wr_index[9:5] = 5'd7; wr_data[63:32] = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    rd_valid = 4'b0100; rd_index[14:10] = 5'd7;
    #1;
    checkCount++;
    if (rd_ready !== 4'b0100 || rf_read_req !== 5'd7)
      $display("FAIL read_grant rd_ready=%b req=%0d required 0100/7", rd_ready, rf_read_req);
    else passCount++;
    step();
    checkCount++;
    if (rd_resp_valid !== 1'b1 || rd_resp_id !== 2'd2 || rd_resp_data !== 32'hDEAD_BEEF)
      $display("FAIL read_resp got=%b/%0d/%h required 1/2/deadbeef", rd_resp_valid, rd_resp_id, rd_resp_data);
    else passCount++;
    rd_valid = '0;
    step();
    checkCount++;
    if (rd_resp_valid !== 1'b0 || rd_resp_id !== 2'd2 || rd_resp_data !== 32'hDEAD_BEEF)
      $display("FAIL read_hold got=%b/%0d/%h required 0/2/deadbeef", rd_resp_valid, rd_resp_id, rd_resp_data);
    else passCount++;
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    wr_valid = 4'b0001; wr_index[4:0] = 5'd3; wr_data[31:0] = 32'h5;
    step();
    wr_data[31:0] = 32'h1234;
    rd_valid = 4'b0010; rd_index[9:5] = 5'd3;
    #1;
    checkCount++;
    if (wr_ready !== 4'b0001 || rd_ready !== 4'b0010)
      $display("FAIL same_grants wr=%b rd=%b required 0001/0010", wr_ready, rd_ready);
    else passCount++;
    step();
    wr_valid = '0;
    checkCount++;
    if (rd_resp_valid !== 1'b1 || rd_resp_id !== 2'd1 || rd_resp_data !== 32'h5)
      $display("FAIL same_old got=%b/%0d/%h required 1/1/5", rd_resp_valid, rd_resp_id, rd_resp_data);
    else passCount++;
    step();
    checkCount++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 32'h1234)
      $display("FAIL same_reread got=%b/%h required 1/1234", rd_resp_valid, rd_resp_data);
    else passCount++;
    idle_inputs();
  endtask

  task automatic test_rr_skip();
    logic [3:0] expWr [3];
    logic [1:0] expId [3];
    expWr = '{4'b0010, 4'b1000, 4'b0010};
    expId = '{2'd2, 2'd0, 2'd2};
    wr_valid = 4'b1010; rd_valid = 4'b0101;
    wr_index[9:5] = 5'd20; wr_index[19:15] = 5'd21;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkCount++;
      if (wr_ready !== expWr[k]) $display("FAIL skip_wr_%0d got=%b required=%b", k, wr_ready, expWr[k]);
      else passCount++;
      step();
      checkCount++;
      if (rd_resp_valid !== 1'b1 || rd_resp_id !== expId[k])
        $display("FAIL skip_rd_%0d got=%b/%0d required 1/%0d", k, rd_resp_valid, rd_resp_id, expId[k]);
      else passCount++;
    end
    idle_inputs();
  endtask

  task automatic test_idle();
    idle_inputs();
    #1;
    checkCount++;
    if (wr_ready !== 4'b0 || rd_ready !== 4'b0 || rf_write_en !== 1'b0 ||
        rf_write_index !== 5'd0 || rf_write_data !== 32'd0)
      $display("FAIL idle_outputs wr=%b rd=%b en=%b idx=%0d data=%h required all 0",
               wr_ready, rd_ready, rf_write_en, rf_write_index, rf_write_data);
    else passCount++;
    step();
    checkCount++;
    if (rd_resp_valid !== 1'b0) $display("FAIL idle_resp got=%b required=0", rd_resp_valid); else passCount++;
  endtask

  task automatic test_async_reset();
    rd_valid = 4'b0001; rd_index[4:0] = 5'd3;
    step();
    checkCount++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 32'h1234)
      $display("FAIL async_pre got=%b/%h required 1/1234", rd_resp_valid, rd_resp_data);
    else passCount++;
    wr_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({rd_resp_valid, rd_resp_id, rd_resp_data} !== 35'd0 || wr_ready !== 4'b0 || rd_ready !== 4'b0)
      $display("FAIL async_reset resp=%b/%0d/%h wr=%b rd=%b required all 0",
               rd_resp_valid, rd_resp_id, rd_resp_data, wr_ready, rd_ready);
    else passCount++;
    do_reset();
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_ARB_CLEAR_EN
    test_clear();
    test_mid_clear_reset();
`else
    test_first_cycle();
`endif
    test_write_rr();
    test_read();
    test_same_cycle();
    test_rr_skip();
    test_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
